rv_ctrl_sequencer: RTL and testbench
====================================

Name: rv_ctrl_sequencer

Overview:
- Parametrised, microcode-style successor to the single-bus CPU's hardwired control unit.
- Decodes the IR opcode into a class and a step counter T3..T7, and drives one registered control word onto the datapath.
- Adds memory wait-states with a timeout, illegal-opcode trapping, and instruction-boundary halt.
- Sits between the IR/CON FF and the register file, ALU, MDR/MAR and I/O ports.

Parameters:
- DATA_W, 32: IR width.
- OP_MSB, 31: MSB of the opcode field in ir_data.
- OP_W, 5: opcode width.
- MEM_WAIT_MAX, 15: mem_ready wait cycles before timeout (1..255).
- WAIT_CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ir_data  in  DATA_W  instruction register contents
- con_out  in  1  branch condition from the CON FF
- mem_ready  in  1  memory completes the current read/write this cycle
- stop  in  1  halt request, level
- ctrl  out  CTRL_W  registered control strobes; bit indices are defined in the package
- alu_op  out  4  ALU operation
- run  out  1  CPU running
- illegal_op  out  1  sticky: undefined opcode trapped
- mem_timeout  out  1  sticky: mem_ready never arrived
- state_dbg  out  4  current FSM state encoding

Behaviour:
- Reset (async):
  - state=RESET, step=0, wait_cnt=0.
  - ctrl=0, alu_op=And (0), run=0.
  - illegal_op=0, mem_timeout=0.
- Timing and outputs:
  - All transitions and output updates occur on posedge clk.
  - Outputs are Moore: a function of (state, opcode class, step) only.
  - Every strobe not listed for a step is 0.
- State transitions:
  - RESET -> F0 (run=1).
  - F0 -> F1 -> F2 -> EXEC(T3).
  - EXEC advances T3 -> last step of the class, then goes to F0.
- Fetch steps:
  - F0: pc_out, mar_in, inc_pc, z_in, alu_op=Add.
  - F1: z_low_out, pc_in, read, mdr_in. Held until mem_ready=1.
  - F2: mdr_out, ir_in. The opcode is latched on exit from F2 and held for EXEC.
- Execution sequences:
  - ld: T3 grb, ba_out, y_in; T4 c_out, Add, z_in; T5 z_low_out, mar_in; T6 read, mdr_in (memory step); T7 mdr_out, gra, r_in.
  - ldi: T3 and T4 as ld; T5 z_low_out, gra, r_in.
  - st: T3..T5 as ld; T6 gra, r_out, mdr_in; T7 write (memory step).
  - add/sub/shr/shl/ror/rol/and/or: T3 grb, r_out, y_in; T4 grc, r_out, op, z_in; T5 z_low_out, gra, r_in.
  - addi/andi/ori: as the R-type sequence, but T4 uses c_out instead of grc/r_out; op is Add/And/Or.
  - mul/div: T3 gra, r_out, y_in; T4 grb, r_out, op, z_in; T5 z_low_out, lo_in; T6 z_high_out, hi_in.
  - neg/not: T3 grb, r_out, op, z_in; T4 z_low_out, gra, r_in.
  - br: T3 gra, r_out, con_in; T4 pc_out, y_in; T5 c_out, Add, z_in; T6 z_low_out, plus pc_in only if con_out=1 when T6 is entered.
  - jr: T3 gra, r_out, pc_in.
  - jal: T3 r_in, pc_out; T4 gra, r_out, pc_in.
  - in: T3 gra, r_in, inport_out.
  - out: T3 gra, r_out, outport_in.
  - mfhi: T3 hi_out, gra, r_in.
  - mflo: T3 lo_out, gra, r_in.
  - nop: F2 -> F0, with no EXEC cycles.
  - halt: F2 -> HALT.
- Memory wait:
  - In F1, ld T6 and st T7, while mem_ready=0: hold state and outputs, increment wait_cnt.
  - When mem_ready=1: advance and clear wait_cnt.
  - When wait_cnt reaches MEM_WAIT_MAX with mem_ready still 0: go to TIMEOUT, set mem_timeout=1, run=0, ctrl=0.
  - mem_ready arriving in the same cycle the count hits MEM_WAIT_MAX counts as success.
- Illegal opcode:
  - Opcodes 27..31 at F2 go to ILLEGAL: illegal_op=1, run=0, ctrl=0.
- stop:
  - Sampled only in the last step of an instruction (and in F0 after reset). If 1, go to HALT instead of F0.
  - An instruction in flight always completes.
- HALT, ILLEGAL and TIMEOUT are terminal: run=0, ctrl=0. Only reset_n leaves them.
- Reset mid-instruction (including mid-wait) returns immediately to the reset values. Sticky flags clear.

Optional Feature:
- Macro RV_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit) and output step_wait (1 bit).
  - After each instruction's last step the FSM enters STEP_WAIT (ctrl=0, run=1, step_wait=1).
  - It proceeds to F0 on a cycle with step=1.
  - stop=1 in STEP_WAIT goes to HALT.
- Undefined: no port, no state; behaviour exactly as above.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants (ld=0 .. halt=26);
  - ALU op constants (And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Mul=8, Div=9, Neg=10, Not=11);
  - FSM state encodings;
  - opcode-class enum;
  - CTRL_W and the ctrl bit indices.
- One sub-module, rv_mem_wait_timer: counter with clear, enable and a hit flag at MEM_WAIT_MAX.

Test Plan:
- add r1,r2,r3 with mem_ready tied 1 -> F0..T5 in 6 cycles; T4 shows grc, r_out, z_in, alu_op=2; T5 shows gra, r_in, z_low_out.
- ld with mem_ready low for 3 cycles in T6 -> read and mdr_in held 4 cycles; T7 follows; wait_cnt back to 0.
- F1 with mem_ready held 0 and MEM_WAIT_MAX=15 -> TIMEOUT after 15 wait cycles; mem_timeout=1, run=0.
- br with con_out=0, then with con_out=1 -> pc_in low in T6 for the first, high for the second; z_low_out asserted in both.
- Opcode 0x1D at F2 -> ILLEGAL, illegal_op=1. A later reset_n pulse clears it and run=1 after RESET.
- stop raised during mul T4 -> T5 and T6 still execute, then HALT; hi_in seen in T6.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the microcoded control sequencer: opcodes, ALU ops, FSM states, opcode classes, ctrl bit map.
// Optional feature macro: RV_CTRL_SINGLE_STEP_EN adds the STEP_WAIT state.
package rv_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3,
                         OP_SUB  = 5'd4,  OP_SHR  = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7,
                         OP_ROL  = 5'd8,  OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11,
                         OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15,
                         OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18, OP_JR   = 5'd19,
                         OP_JAL  = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23,
                         OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,  ALU_SUB = 4'd3,
                         ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6,  ALU_ROL = 4'd7,
                         ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0, ST_F0 = 4'd1, ST_F1 = 4'd2, ST_F2 = 4'd3, ST_EXEC = 4'd4,
    ST_HALT = 4'd5, ST_ILLEGAL = 4'd6, ST_TIMEOUT = 4'd7
`ifdef RV_CTRL_SINGLE_STEP_EN
    , ST_STEP_WAIT = 4'd8
`endif
  } state_e;

  typedef enum logic [4:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ALUI, CL_MULDIV, CL_UNARY, CL_BR, CL_JR,
    CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
  } cls_e;

  localparam int C_PC_OUT = 0,  C_MAR_IN = 1,  C_INC_PC = 2,   C_Z_IN = 3,     C_ZLO_OUT = 4,
                 C_ZHI_OUT = 5, C_PC_IN = 6,   C_READ = 7,     C_WRITE = 8,    C_MDR_IN = 9,
                 C_MDR_OUT = 10, C_IR_IN = 11, C_GRA = 12,     C_GRB = 13,     C_GRC = 14,
                 C_BA_OUT = 15, C_R_IN = 16,   C_R_OUT = 17,   C_Y_IN = 18,    C_C_OUT = 19,
                 C_CON_IN = 20, C_LO_IN = 21,  C_HI_IN = 22,   C_LO_OUT = 23,  C_HI_OUT = 24,
                 C_INP_OUT = 25, C_OUTP_IN = 26;
  localparam int CTRL_W = 27;

  function automatic logic [CTRL_W-1:0] cb(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

  function automatic cls_e op_class(input logic [4:0] op);
    case (op)
      OP_LD:   return CL_LD;
      OP_LDI:  return CL_LDI;
      OP_ST:   return CL_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: return CL_ALUI;
      OP_MUL, OP_DIV: return CL_MULDIV;
      OP_NEG, OP_NOT: return CL_UNARY;
      OP_BR:   return CL_BR;
      OP_JR:   return CL_JR;
      OP_JAL:  return CL_JAL;
      OP_IN:   return CL_IN;
      OP_OUT:  return CL_OUT;
      OP_MFHI: return CL_MFHI;
      OP_MFLO: return CL_MFLO;
      OP_NOP:  return CL_NOP;
      OP_HALT: return CL_HALT;
      default: return CL_ILL;
    endcase
  endfunction

  function automatic logic [3:0] op_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] last_step(input cls_e c);
    case (c)
      CL_LD, CL_ST:               return 3'd7;
      CL_MULDIV, CL_BR:           return 3'd6;
      CL_LDI, CL_ALU, CL_ALUI:    return 3'd5;
      CL_UNARY, CL_JAL:           return 3'd4;
      default:                    return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_wait_timer.sv
// Memory wait-state counter: clear has priority over enable; o_hit flags the count at MAX.
module rv_mem_wait_timer #(
  parameter int MAX = 15,
  parameter int W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_hit = (r_cnt == W'(MAX));
endmodule

// File: rtl/rv_ctrl_sequencer.sv
// Microcoded control sequencer: fetch/exec FSM with a registered control word, memory wait timeout and illegal trap.
// Optional feature macro: RV_CTRL_SINGLE_STEP_EN (step input, step_wait output, STEP_WAIT state).
module rv_ctrl_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int OP_MSB       = 31,
  parameter int OP_W         = 5,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ir_data,
  input  logic              con_out,
  input  logic              mem_ready,
  input  logic              stop,
`ifdef RV_CTRL_SINGLE_STEP_EN
  input  logic              step,
  output logic              step_wait,
`endif
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        alu_op,
  output logic              run,
  output logic              illegal_op,
  output logic              mem_timeout,
  output logic [3:0]        state_dbg
);
  state_e            r_state, w_state_nxt, w_end_tgt;
  logic [2:0]        r_tstep, w_tstep_nxt;
  logic [4:0]        r_opc, w_opc_ir, w_opc_nxt;
  cls_e              w_cls_cur, w_cls_nxt;
  logic              w_mem_step, w_wait, w_hit, w_wait_clr, w_wait_en;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
  logic [3:0]        r_alu, w_alu_nxt;
  logic              r_run, w_run_nxt, r_ill, r_tmo;
  logic              w_unused_ir;

  assign w_opc_ir    = 5'(ir_data[OP_MSB -: OP_W]);
  assign w_unused_ir = ^ir_data;
  assign w_opc_nxt   = (r_state == ST_F2) ? w_opc_ir : r_opc;
  assign w_cls_cur   = op_class(r_opc);
  assign w_cls_nxt   = op_class(w_opc_nxt);

  assign w_mem_step = (r_state == ST_F1) ||
                      ((r_state == ST_EXEC) && (((w_cls_cur == CL_LD) && (r_tstep == 3'd6)) ||
                                                ((w_cls_cur == CL_ST) && (r_tstep == 3'd7))));
  assign w_wait     = w_mem_step && !mem_ready;
  assign w_wait_clr = !w_wait;
  assign w_wait_en  = w_wait && !w_hit;

  rv_mem_wait_timer #(.MAX(MEM_WAIT_MAX), .W(WAIT_CNT_W)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_wait_clr),
    .i_en    (w_wait_en),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_tstep <= '0;
      r_opc   <= '0;
      r_ctrl  <= '0;
      r_alu   <= ALU_AND;
      r_run   <= 1'b0;
      r_ill   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tstep <= w_tstep_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_alu   <= w_alu_nxt;
      r_run   <= w_run_nxt;
      if (r_state == ST_F2)            r_opc <= w_opc_ir;
      if (w_state_nxt == ST_ILLEGAL)   r_ill <= 1'b1;
      if (w_state_nxt == ST_TIMEOUT)   r_tmo <= 1'b1;
    end
  end

  // stop is only honoured where an instruction boundary would otherwise lead to F0
  always_comb begin
    w_state_nxt = r_state;
    w_tstep_nxt = '0;
`ifdef RV_CTRL_SINGLE_STEP_EN
    w_end_tgt   = stop ? ST_HALT : ST_STEP_WAIT;
`else
    w_end_tgt   = stop ? ST_HALT : ST_F0;
`endif
    case (r_state)
      ST_RESET: w_state_nxt = stop ? ST_HALT : ST_F0;
      ST_F0:    w_state_nxt = ST_F1;
      ST_F1: begin
        if (!w_wait)    w_state_nxt = ST_F2;
        else if (w_hit) w_state_nxt = ST_TIMEOUT;
      end
      ST_F2: begin
        case (op_class(w_opc_ir))
          CL_ILL:  w_state_nxt = ST_ILLEGAL;
          CL_HALT: w_state_nxt = ST_HALT;
          CL_NOP:  w_state_nxt = w_end_tgt;
          default: begin
            w_state_nxt = ST_EXEC;
            w_tstep_nxt = 3'd3;
          end
        endcase
      end
      ST_EXEC: begin
        w_tstep_nxt = r_tstep;
        if (w_wait) begin
          if (w_hit) begin
            w_state_nxt = ST_TIMEOUT;
            w_tstep_nxt = '0;
          end
        end else if (r_tstep == last_step(w_cls_cur)) begin
          w_state_nxt = w_end_tgt;
          w_tstep_nxt = '0;
        end else begin
          w_tstep_nxt = r_tstep + 3'd1;
        end
      end
`ifdef RV_CTRL_SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (stop)      w_state_nxt = ST_HALT;
        else if (step) w_state_nxt = ST_F0;
      end
`endif
      default: ;
    endcase
  end

  // Control word is decoded from the next state so it lines up with state_dbg
  always_comb begin
    w_ctrl_nxt = '0;
    w_alu_nxt  = ALU_AND;
    w_run_nxt  = 1'b1;
    case (w_state_nxt)
      ST_F0: begin
        w_ctrl_nxt = cb(C_PC_OUT) | cb(C_MAR_IN) | cb(C_INC_PC) | cb(C_Z_IN);
        w_alu_nxt  = ALU_ADD;
      end
      ST_F1: w_ctrl_nxt = cb(C_ZLO_OUT) | cb(C_PC_IN) | cb(C_READ) | cb(C_MDR_IN);
      ST_F2: w_ctrl_nxt = cb(C_MDR_OUT) | cb(C_IR_IN);
      ST_EXEC: begin
        case (w_cls_nxt)
          CL_LD, CL_LDI, CL_ST: begin
            case (w_tstep_nxt)
              3'd3: w_ctrl_nxt = cb(C_GRB) | cb(C_BA_OUT) | cb(C_Y_IN);
              3'd4: begin
                w_ctrl_nxt = cb(C_C_OUT) | cb(C_Z_IN);
                w_alu_nxt  = ALU_ADD;
              end
              3'd5: w_ctrl_nxt = (w_cls_nxt == CL_LDI) ? (cb(C_ZLO_OUT) | cb(C_GRA) | cb(C_R_IN))
                                                       : (cb(C_ZLO_OUT) | cb(C_MAR_IN));
              3'd6: w_ctrl_nxt = (w_cls_nxt == CL_LD) ? (cb(C_READ) | cb(C_MDR_IN))
                                                      : (cb(C_GRA) | cb(C_R_OUT) | cb(C_MDR_IN));
              3'd7: w_ctrl_nxt = (w_cls_nxt == CL_LD) ? (cb(C_MDR_OUT) | cb(C_GRA) | cb(C_R_IN))
                                                      : cb(C_WRITE);
              default: ;
            endcase
          end
          CL_ALU, CL_ALUI: begin
            case (w_tstep_nxt)
              3'd3: w_ctrl_nxt = cb(C_GRB) | cb(C_R_OUT) | cb(C_Y_IN);
              3'd4: begin
                w_ctrl_nxt = cb(C_Z_IN) | ((w_cls_nxt == CL_ALU) ? (cb(C_GRC) | cb(C_R_OUT)) : cb(C_C_OUT));
                w_alu_nxt  = op_alu(w_opc_nxt);
              end
              3'd5: w_ctrl_nxt = cb(C_ZLO_OUT) | cb(C_GRA) | cb(C_R_IN);
              default: ;
            endcase
          end
          CL_MULDIV: begin
            case (w_tstep_nxt)
              3'd3: w_ctrl_nxt = cb(C_GRA) | cb(C_R_OUT) | cb(C_Y_IN);
              3'd4: begin
                w_ctrl_nxt = cb(C_GRB) | cb(C_R_OUT) | cb(C_Z_IN);
                w_alu_nxt  = op_alu(w_opc_nxt);
              end
              3'd5: w_ctrl_nxt = cb(C_ZLO_OUT) | cb(C_LO_IN);
              3'd6: w_ctrl_nxt = cb(C_ZHI_OUT) | cb(C_HI_IN);
              default: ;
            endcase
          end
          CL_UNARY: begin
            if (w_tstep_nxt == 3'd3) begin
              w_ctrl_nxt = cb(C_GRB) | cb(C_R_OUT) | cb(C_Z_IN);
              w_alu_nxt  = op_alu(w_opc_nxt);
            end else begin
              w_ctrl_nxt = cb(C_ZLO_OUT) | cb(C_GRA) | cb(C_R_IN);
            end
          end
          CL_BR: begin
            case (w_tstep_nxt)
              3'd3: w_ctrl_nxt = cb(C_GRA) | cb(C_R_OUT) | cb(C_CON_IN);
              3'd4: w_ctrl_nxt = cb(C_PC_OUT) | cb(C_Y_IN);
              3'd5: begin
                w_ctrl_nxt = cb(C_C_OUT) | cb(C_Z_IN);
                w_alu_nxt  = ALU_ADD;
              end
              3'd6: w_ctrl_nxt = cb(C_ZLO_OUT) | (con_out ? cb(C_PC_IN) : '0);
              default: ;
            endcase
          end
          CL_JR:   w_ctrl_nxt = cb(C_GRA) | cb(C_R_OUT) | cb(C_PC_IN);
          CL_JAL:  w_ctrl_nxt = (w_tstep_nxt == 3'd3) ? (cb(C_R_IN) | cb(C_PC_OUT))
                                                      : (cb(C_GRA) | cb(C_R_OUT) | cb(C_PC_IN));
          CL_IN:   w_ctrl_nxt = cb(C_GRA) | cb(C_R_IN) | cb(C_INP_OUT);
          CL_OUT:  w_ctrl_nxt = cb(C_GRA) | cb(C_R_OUT) | cb(C_OUTP_IN);
          CL_MFHI: w_ctrl_nxt = cb(C_HI_OUT) | cb(C_GRA) | cb(C_R_IN);
          CL_MFLO: w_ctrl_nxt = cb(C_LO_OUT) | cb(C_GRA) | cb(C_R_IN);
          default: ;
        endcase
      end
`ifdef RV_CTRL_SINGLE_STEP_EN
      ST_STEP_WAIT: ;
`endif
      default: w_run_nxt = 1'b0;
    endcase
  end

`ifdef RV_CTRL_SINGLE_STEP_EN
  logic r_sw;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sw <= 1'b0;
    else          r_sw <= (w_state_nxt == ST_STEP_WAIT);
  end
  assign step_wait = r_sw;
`endif

  assign ctrl        = r_ctrl;
  assign alu_op      = r_alu;
  assign run         = r_run;
  assign illegal_op  = r_ill;
  assign mem_timeout = r_tmo;
  assign state_dbg   = r_state;
endmodule

// File: tb/tb_rv_ctrl_sequencer.sv
// Directed bench: expected per-cycle state/ctrl/alu/run tuples are queued, then popped and checked each cycle.
module tb_rv_ctrl_sequencer;
  import rv_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n, con_out, mem_ready, stop;
  logic [31:0]       ir_data;
  logic [CTRL_W-1:0] ctrl;
  logic [3:0]        alu_op, state_dbg;
  logic              run, illegal_op, mem_timeout;
`ifdef RV_CTRL_SINGLE_STEP_EN
  logic              step = 1'b1;
  logic              step_wait;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string             tag;
    logic [3:0]        st;
    logic [CTRL_W-1:0] cw;
    logic [3:0]        alu;
    logic              run;
  } exp_t;
  exp_t q[$];

  rv_ctrl_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ir_data     (ir_data),
    .con_out     (con_out),
    .mem_ready   (mem_ready),
    .stop        (stop),
`ifdef RV_CTRL_SINGLE_STEP_EN
    .step        (step),
    .step_wait   (step_wait),
`endif
    .ctrl        (ctrl),
    .alu_op      (alu_op),
    .run         (run),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [CTRL_W-1:0] cw(input int a = -1, input int b = -1,
                                           input int c = -1, input int d = -1);
    logic [CTRL_W-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] ir(input logic [4:0] op);
    logic [31:0] v;
    v = '0;
    v[31:27] = op;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input state_e st, input logic [CTRL_W-1:0] c,
                      input logic [3:0] alu, input logic r);
    exp_t e;
    e.tag = tag; e.st = st; e.cw = c; e.alu = alu; e.run = r;
    q.push_back(e);
  endtask

  task automatic run_cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = q.pop_front();
        chk({e.tag, ".state"}, state_dbg, e.st);
        chk({e.tag, ".ctrl"},  ctrl,      e.cw);
        chk({e.tag, ".alu"},   alu_op,    e.alu);
        chk({e.tag, ".run"},   run,       e.run);
      end
    end
  endtask

  task automatic fetch(input string tag);
    push({tag, ".f0"}, ST_F0, cw(C_PC_OUT, C_MAR_IN, C_INC_PC, C_Z_IN), ALU_ADD, 1'b1);
    push({tag, ".f1"}, ST_F1, cw(C_ZLO_OUT, C_PC_IN, C_READ, C_MDR_IN), ALU_AND, 1'b1);
    push({tag, ".f2"}, ST_F2, cw(C_MDR_OUT, C_IR_IN), ALU_AND, 1'b1);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0; stop = 1'b0; mem_ready = 1'b1; con_out = 1'b0;
    push({tag, ".rst"}, ST_RESET, '0, ALU_AND, 1'b0);
    run_cyc(1);
    chk({tag, ".ill_clr"}, illegal_op, 1'b0);
    chk({tag, ".tmo_clr"}, mem_timeout, 1'b0);
    chk({tag, ".cnt_clr"}, dut.u_wait.r_cnt, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; ir_data = '0; con_out = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    do_reset("por");

    ir_data = ir(OP_ADD);
    fetch("add");
    push("add.t3", ST_EXEC, cw(C_GRB, C_R_OUT, C_Y_IN), ALU_AND, 1'b1);
    push("add.t4", ST_EXEC, cw(C_GRC, C_R_OUT, C_Z_IN), ALU_ADD, 1'b1);
    push("add.t5", ST_EXEC, cw(C_ZLO_OUT, C_GRA, C_R_IN), ALU_AND, 1'b1);
    run_cyc(6);

    // ld: three wait cycles in T6 keep read/mdr_in up for four cycles
    ir_data = ir(OP_LD);
    fetch("ld");
    push("ld.t3", ST_EXEC, cw(C_GRB, C_BA_OUT, C_Y_IN), ALU_AND, 1'b1);
    push("ld.t4", ST_EXEC, cw(C_C_OUT, C_Z_IN), ALU_ADD, 1'b1);
    push("ld.t5", ST_EXEC, cw(C_ZLO_OUT, C_MAR_IN), ALU_AND, 1'b1);
    for (int i = 0; i < 4; i++) push("ld.t6", ST_EXEC, cw(C_READ, C_MDR_IN), ALU_AND, 1'b1);
    push("ld.t7", ST_EXEC, cw(C_MDR_OUT, C_GRA, C_R_IN), ALU_AND, 1'b1);
    run_cyc(7);
    mem_ready = 1'b0;
    run_cyc(2);
    chk("ld.cnt_mid", dut.u_wait.r_cnt, 2);
    run_cyc(1);
    mem_ready = 1'b1;
    run_cyc(1);
    chk("ld.cnt_end", dut.u_wait.r_cnt, 0);

    ir_data = ir(OP_ORI);
    fetch("ori");
    push("ori.t3", ST_EXEC, cw(C_GRB, C_R_OUT, C_Y_IN), ALU_AND, 1'b1);
    push("ori.t4", ST_EXEC, cw(C_C_OUT, C_Z_IN), ALU_OR, 1'b1);
    push("ori.t5", ST_EXEC, cw(C_ZLO_OUT, C_GRA, C_R_IN), ALU_AND, 1'b1);
    run_cyc(6);

    for (int k = 0; k < 2; k++) begin
      con_out = (k == 1);
      ir_data = ir(OP_BR);
      fetch("br");
      push("br.t3", ST_EXEC, cw(C_GRA, C_R_OUT, C_CON_IN), ALU_AND, 1'b1);
      push("br.t4", ST_EXEC, cw(C_PC_OUT, C_Y_IN), ALU_AND, 1'b1);
      push("br.t5", ST_EXEC, cw(C_C_OUT, C_Z_IN), ALU_ADD, 1'b1);
      push(k == 1 ? "br1.t6" : "br0.t6", ST_EXEC,
           (k == 1) ? cw(C_ZLO_OUT, C_PC_IN) : cw(C_ZLO_OUT), ALU_AND, 1'b1);
      run_cyc(7);
    end
    con_out = 1'b0;

    // stop in mul T4: T5/T6 still run, then HALT
    ir_data = ir(OP_MUL);
    fetch("mul");
    push("mul.t3", ST_EXEC, cw(C_GRA, C_R_OUT, C_Y_IN), ALU_AND, 1'b1);
    push("mul.t4", ST_EXEC, cw(C_GRB, C_R_OUT, C_Z_IN), ALU_MUL, 1'b1);
    push("mul.t5", ST_EXEC, cw(C_ZLO_OUT, C_LO_IN), ALU_AND, 1'b1);
    push("mul.t6", ST_EXEC, cw(C_ZHI_OUT, C_HI_IN), ALU_AND, 1'b1);
    push("mul.halt", ST_HALT, '0, ALU_AND, 1'b0);
    push("mul.halt2", ST_HALT, '0, ALU_AND, 1'b0);
    run_cyc(5);
    stop = 1'b1;
    run_cyc(4);
    do_reset("r1");

    // nop with mem_ready arriving exactly when the wait count hits the limit, then halt opcode
    ir_data = ir(OP_NOP);
    push("nop.f0", ST_F0, cw(C_PC_OUT, C_MAR_IN, C_INC_PC, C_Z_IN), ALU_ADD, 1'b1);
    for (int i = 0; i < 16; i++) push("nop.f1", ST_F1, cw(C_ZLO_OUT, C_PC_IN, C_READ, C_MDR_IN), ALU_AND, 1'b1);
    push("nop.f2", ST_F2, cw(C_MDR_OUT, C_IR_IN), ALU_AND, 1'b1);
    run_cyc(1);
    mem_ready = 1'b0;
    run_cyc(16);
    chk("nop.cnt_max", dut.u_wait.r_cnt, 15);
    mem_ready = 1'b1;
    run_cyc(1);
    fetch("hlt");
    push("hlt.halt", ST_HALT, '0, ALU_AND, 1'b0);
    push("hlt.halt2", ST_HALT, '0, ALU_AND, 1'b0);
    run_cyc(1);
    ir_data = ir(OP_HALT);
    run_cyc(4);
    do_reset("r2");

    ir_data = 32'h1D << 27;
    fetch("ill");
    push("ill.trap", ST_ILLEGAL, '0, ALU_AND, 1'b0);
    push("ill.trap2", ST_ILLEGAL, '0, ALU_AND, 1'b0);
    run_cyc(5);
    chk("ill.flag", illegal_op, 1'b1);
    chk("ill.tmo", mem_timeout, 1'b0);
    do_reset("r3");

    // F1 timeout: 15 counted waits, then the hit cycle without mem_ready
    ir_data = ir(OP_NOP);
    push("tmo.f0", ST_F0, cw(C_PC_OUT, C_MAR_IN, C_INC_PC, C_Z_IN), ALU_ADD, 1'b1);
    for (int i = 0; i < 16; i++) push("tmo.f1", ST_F1, cw(C_ZLO_OUT, C_PC_IN, C_READ, C_MDR_IN), ALU_AND, 1'b1);
    push("tmo.trap", ST_TIMEOUT, '0, ALU_AND, 1'b0);
    push("tmo.trap2", ST_TIMEOUT, '0, ALU_AND, 1'b0);
    run_cyc(1);
    mem_ready = 1'b0;
    run_cyc(18);
    chk("tmo.flag", mem_timeout, 1'b1);
    chk("tmo.ill", illegal_op, 1'b0);
    do_reset("r4");

    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
